// File: rtl/log2_pkg.sv
// Shared widths, error code and FSM state type for the Log2 core front-end.
package log2_pkg;
  localparam int LOG2_W    = 8;
  localparam int LOG2_FRAC = 5;
  localparam logic [LOG2_W-1:0] LOG2_ERR_VAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/log2_fifo.sv
// DEPTH x LOG2_W synchronous FIFO; head word is readable combinationally while non-empty.
module log2_fifo
  import log2_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LOG2_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [LOG2_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);
  logic [LOG2_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + (AW+1)'(1);
    else if (do_rd && !do_wr) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/log2_feeder.sv
// Buffers samples, sequences the serial Log2 core one operand at a time and
// returns each result (or a local zero/timeout error) over a valid/ready stream.
module log2_feeder
  import log2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LOG2_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LOG2_W-1:0] res_data,
  output logic              res_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [LOG2_W-1:0] core_in,
  output logic              core_h,
  input  logic              core_flag,
  input  logic [LOG2_W-1:0] core_out,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  feeder_state_t     state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [LOG2_W-1:0] operand_q, operand_d;
  logic [LOG2_W-1:0] res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              res_valid_q, res_valid_d;
  logic              core_h_q, core_h_d;

  logic              fifo_pop;
  logic [LOG2_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;

  log2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (in_data),
    .wr_en   (in_valid),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // core_h_q mirrors "next state is ISSUE" so the core sees a clean registered strobe.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    operand_d   = operand_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q && !res_ready;
    core_h_d    = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (!res_valid_q || res_ready)) begin
          fifo_pop = 1'b1;
          if (fifo_head == '0) begin
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
          end else begin
            operand_d = fifo_head;
            timer_d   = '0;
            state_d   = ST_ISSUE;
            core_h_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (core_flag) begin
          res_data_d  = core_out;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_GAP;
        end else if (timer_q == TIMER_LAST) begin
          res_data_d  = LOG2_ERR_VAL;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_GAP;
        end else begin
          timer_d  = timer_q + TW'(1);
          core_h_d = 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      operand_q   <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      core_h_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      operand_q   <= operand_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      core_h_q    <= core_h_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign core_in   = operand_q;
  assign core_h    = core_h_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
endmodule
